// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt controller.
package int_pkg;

  localparam int unsigned AddrW  = 16;
  localparam int unsigned MaxIrq = 8;
  localparam int unsigned IdxW   = 3;

  typedef enum logic [1:0] {
    StIdle,
    StSave,
    StVector,
    StService
  } state_e;

  // 16-bit vector address; overflow wraps.
  function automatic logic [AddrW-1:0] vec_addr_calc(input logic [AddrW-1:0] base,
                                                     input logic [AddrW-1:0] stride,
                                                     input logic [IdxW-1:0]  idx);
    return base + stride * AddrW'(idx);
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Per-line interrupt synchroniser producing the registered pending bit.
// INT_EDGE_EN selects a sticky rising-edge pending bit instead of a level copy.
module irq_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic irq_i,
  input  logic clr_i,
  output logic pend_o
);

  logic sync1_q, sync2_q, pend_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef INT_EDGE_EN
  logic prev_q, rise_q;

  // A new edge coinciding with the acknowledge clear keeps the bit set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= sync2_q;
      rise_q <= sync2_q & ~prev_q;
      pend_q <= rise_q | (pend_q & ~clr_i);
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= sync2_q;
    end
  end
`endif

  assign pend_o = pend_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: prioritises masked requests and sequences push/vector/service.
// Optional INT_EDGE_EN makes pending bits edge-triggered and cleared on acknowledge.
module int_ctrl
  import int_pkg::*;
#(
  parameter int unsigned      NIrq      = 4,
  parameter logic [AddrW-1:0] VecBase   = 16'h0010,
  parameter int unsigned      VecStride = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NIrq-1:0]  irq_i,
  input  logic             mask_we_i,
  input  logic [NIrq-1:0]  mask_i,
  input  logic             ei_i,
  input  logic             di_i,
  input  logic             reti_i,
  input  logic             instr_done_i,
  output logic             cpu_hold_o,
  output logic             int_push_o,
  output logic             vec_load_o,
  output logic [AddrW-1:0] vec_addr_o,
  output logic [NIrq-1:0]  int_ack_o,
  output logic             in_service_o,
  output logic [NIrq-1:0]  pending_o
);

  state_e           state_q, state_d;
  logic             gie_q, gie_d;
  logic [NIrq-1:0]  mask_q, mask_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [AddrW-1:0] vec_addr_q, vec_addr_d;

  logic [NIrq-1:0]  pending, req, ack_vec;
  logic [IdxW-1:0]  win_idx;
  logic             win_hit;
  logic             accept;

  for (genvar i = 0; i < NIrq; i++) begin : g_sync
    irq_sync u_irq_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .irq_i  (irq_i[i]),
      .clr_i  (ack_vec[i]),
      .pend_o (pending[i])
    );
  end

  assign req = pending & mask_q;

  // Lowest index wins.
  always_comb begin
    win_idx = '0;
    win_hit = 1'b0;
    for (int unsigned i = 0; i < NIrq; i++) begin
      if (req[i] && !win_hit) begin
        win_idx = IdxW'(i);
        win_hit = 1'b1;
      end
    end
  end

  // Requests only count in IDLE, which gives the no-nesting behaviour.
  assign accept = (state_q == StIdle) && gie_q && instr_done_i && win_hit;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StSave;
      StSave:    state_d = StVector;
      StVector:  state_d = StService;
      StService: if (reti_i) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    gie_d = gie_q;
    if ((state_q == StService) && reti_i) gie_d = 1'b1;
    if (ei_i) gie_d = 1'b1;
    if (di_i) gie_d = 1'b0;
    if (accept) gie_d = 1'b0;
  end

  always_comb begin
    mask_d     = mask_we_i ? mask_i : mask_q;
    idx_d      = idx_q;
    vec_addr_d = vec_addr_q;
    if (accept) begin
      idx_d      = win_idx;
      vec_addr_d = vec_addr_calc(VecBase, AddrW'(VecStride), win_idx);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      gie_q      <= 1'b0;
      mask_q     <= '0;
      idx_q      <= '0;
      vec_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      gie_q      <= gie_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      vec_addr_q <= vec_addr_d;
    end
  end

  always_comb begin
    ack_vec = '0;
    for (int unsigned i = 0; i < NIrq; i++) begin
      ack_vec[i] = (state_q == StVector) && (idx_q == IdxW'(i));
    end
  end

  assign cpu_hold_o   = (state_q == StSave) || (state_q == StVector);
  assign int_push_o   = (state_q == StSave);
  assign vec_load_o   = (state_q == StVector);
  assign in_service_o = (state_q == StService);
  assign int_ack_o    = ack_vec;
  assign vec_addr_o   = vec_addr_q;
  assign pending_o    = pending;

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller that sequences the CPU datapath and control unit through interrupt entry and return. It samples external interrupt lines, prioritises and masks them, and at an instruction boundary stalls the CPU. It then drives a stack push of the return PC, loads the PC with a vector address, and holds in-service state until the control unit decodes a return-from-interrupt. It sits beside the control unit inside `cpu`, driving the datapath's stack and PC-load controls.

## Interface
- `N_IRQ`, 4: number of interrupt lines (1–8).
- `VEC_BASE`, 16'h0010: vector address of line 0.
- `VEC_STRIDE`, 4: address distance between consecutive vectors.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `irq`  in  N_IRQ  asynchronous interrupt request lines.
- `mask_we`  in  1  write strobe for mask register.
- `mask_in`  in  N_IRQ  new mask value (1 = enabled).
- `ei`  in  1  control unit decoded enable-interrupts.
- `di`  in  1  control unit decoded disable-interrupts.
- `reti`  in  1  control unit decoded return-from-interrupt (stack pop done by datapath).
- `instr_done`  in  1  current instruction completes this cycle.
- `cpu_hold`  out  1  freeze PC increment and register writes.
- `int_push`  out  1  push current PC onto stack.
- `vec_load`  out  1  load PC from `vec_addr`.
- `vec_addr`  out  16  vector address.
- `int_ack`  out  N_IRQ  one-hot acknowledge of the accepted line.
- `in_service`  out  1  handler running.
- `pending`  out  N_IRQ  current pending vector.

## Operation
- Each `irq` line passes through a 2-flop synchroniser to give `irq_s`.
- Default (level mode): `pending = irq_s`. `int_ack` does not clear it; the source must deassert.
- Global enable `gie`:
  - `ei` sets it; `di` clears it. If both are asserted, `di` wins.
  - Cleared on acceptance; set on `reti` in SERVICE.
- `mask` register is written when `mask_we` is high.
- `req = pending & mask`. Lowest index has highest priority.
- FSM states: IDLE, SAVE, VECTOR, SERVICE.
  - IDLE → SAVE when `gie & instr_done & |req`. The winning index is latched and `gie` is cleared.
  - SAVE (1 cycle): `cpu_hold=1`, `int_push=1` → VECTOR.
  - VECTOR (1 cycle): `cpu_hold=1`, `vec_load=1`, `int_ack` = one-hot(latched index) → SERVICE.
  - SERVICE: `in_service=1` until `reti`, then → IDLE with `gie=1`.
- `vec_addr = VEC_BASE + idx*VEC_STRIDE`, computed at 16 bits with wrap (overflow truncated). It is registered at the IDLE→SAVE edge and held until the next acceptance.
- No nesting: `req` is ignored outside IDLE.
- `reti` outside SERVICE is ignored.
- `ei` in SERVICE sets `gie` but has no effect until IDLE.
- Mask changes during SAVE/VECTOR do not alter the latched index.

## Timing
- Reset (async assert, sync release) values:
  - State IDLE; `gie=0`; `mask=0`; synchronisers and `pending` 0.
  - `vec_addr=16'h0000`; all strobes 0; `in_service=0`.
- Reset mid-sequence aborts to IDLE immediately; no partial push or vector load is completed.
- `irq` high before edge k → `pending` visible after edge k+2.
- Acceptance at edge a:
  - `int_push` during cycle a..a+1.
  - `vec_load`/`int_ack` during a+1..a+2.
  - `in_service` from edge a+2.
- `reti` sampled at edge r → IDLE and `gie=1` after r. A new acceptance is possible at edge r+1 if `instr_done`.
- All outputs are registered or decoded only from the state register; there are no combinational paths from inputs to outputs.

## Configuration
- `INT_EDGE_EN` defined: edge mode.
  - `pending[i]` is a register set on a rising edge of `irq_s[i]` (one edge per line).
  - The bit is cleared in the VECTOR cycle for the acknowledged line.
  - If a new edge coincides with the clear, set wins.
  - Adds 1 cycle of latency: `pending` visible after edge k+3.
- Undefined: level mode as above; no edge register is instantiated.

## Structure
- Package `int_pkg`: state enum (IDLE, SAVE, VECTOR, SERVICE), 16-bit address width constant, maximum `N_IRQ`.
- Sub-module `irq_sync`: per-line 2-flop synchroniser plus, under `INT_EDGE_EN`, the rising-edge detector. Instantiated `N_IRQ` times via generate.
- Priority encoder and FSM live in `int_ctrl`.

## Test plan
- Reset, then `ei`, `mask_in=4'b1111`, raise `irq[2]`, `instr_done=1` → `int_push` one cycle, then `vec_load=1`, `vec_addr=16'h0018`, `int_ack=4'b0100`, then `in_service=1`.
- `irq[3]` and `irq[1]` raised together → `int_ack=4'b0010`, `vec_addr=16'h0014`. After `reti` with `irq[1]` dropped, `irq[3]` is accepted with `vec_addr=16'h001C`.
- `mask=4'b0000` or `gie=0` (`di`, or `ei` and `di` in the same cycle) with `irq[0]` high → stays IDLE, `pending=4'b0001`, no strobes.
- Assert `irq[0]` in SERVICE → no second push until `reti`. Acceptance follows 1 cycle after `reti` given `instr_done`.
- `reset` low during VECTOR → all outputs 0 asynchronously, IDLE, `gie=0`.
- `INT_EDGE_EN`: pulse `irq[1]` for 1 cycle → pending latched, cleared at ack. Hold `irq[1]` high after `reti` → no re-entry.
